// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, downstream control and the
// registered instruction handed to the decoder.
interface instruction_fetch_if;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic       stall;
   logic       redirect_en;
   logic [7:0] redirect_pc;
   logic [7:0] if_instr;
   logic [7:0] if_imm;
   logic       if_valid;
   logic [7:0] if_pc_next;

   modport master (
      output imem_addr,
      input  imem_data,
      input  stall,
      input  redirect_en,
      input  redirect_pc,
      output if_instr,
      output if_imm,
      output if_valid,
      output if_pc_next
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output stall,
      output redirect_en,
      output redirect_pc,
      input  if_instr,
      input  if_imm,
      input  if_valid,
      input  if_pc_next
   );
endinterface

// File: rtl/instruction_fetch.sv
// Byte-wide instruction fetch stage: loads the reset vector from M[0], then
// delivers 1-byte and 2-byte (opcode + immediate) instructions to the decoder.
module instruction_fetch #(
   parameter logic [3:0] TWO_BYTE_OPC = 4'd12,
   parameter logic [7:0] NOP_INSTR    = 8'h00
) (
   input  logic                clk,
   input  logic                rst_n,
   instruction_fetch_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_OP   = 2'd1,
      ST_IMM  = 2'd2
   } state_t;

   state_t     r_state;
   logic [7:0] r_pc;
   logic [7:0] r_op_hold;
   logic [7:0] r_instr;
   logic [7:0] r_imm;
   logic       r_valid;
   logic [7:0] r_pc_next;

   logic [7:0] w_pc_inc;
   logic       w_two_byte;

   assign w_pc_inc   = r_pc + 8'd1;
   assign w_two_byte = (bus.imem_data[7:4] == TWO_BYTE_OPC);

   // BOOT reads the reset vector at address 0; afterwards memory follows the PC
   assign bus.imem_addr = (r_state == ST_BOOT) ? 8'h00 : r_pc;

   assign bus.if_instr   = r_instr;
   assign bus.if_imm     = r_imm;
   assign bus.if_valid   = r_valid;
   assign bus.if_pc_next = r_pc_next;

   // Fetch FSM: redirect beats stall beats normal fetch; a stall freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_BOOT;
         r_pc      <= 8'h00;
         r_op_hold <= 8'h00;
         r_instr   <= NOP_INSTR;
         r_imm     <= 8'h00;
         r_valid   <= 1'b0;
         r_pc_next <= 8'h00;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_pc    <= bus.imem_data;
               r_instr <= NOP_INSTR;
               r_imm   <= 8'h00;
               r_valid <= 1'b0;
               r_state <= ST_OP;
            end
            ST_OP: begin
               if (bus.redirect_en) begin
                  r_pc      <= bus.redirect_pc;
                  r_op_hold <= 8'h00;
                  r_instr   <= NOP_INSTR;
                  r_imm     <= 8'h00;
                  r_valid   <= 1'b0;
                  r_state   <= ST_OP;
               end else if (bus.stall) begin
                  r_state <= ST_OP;
               end else if (w_two_byte) begin
                  r_op_hold <= bus.imem_data;
                  r_pc      <= w_pc_inc;
                  r_instr   <= NOP_INSTR;
                  r_imm     <= 8'h00;
                  r_valid   <= 1'b0;
                  r_state   <= ST_IMM;
               end else begin
                  r_instr   <= bus.imem_data;
                  r_imm     <= 8'h00;
                  r_valid   <= 1'b1;
                  r_pc_next <= w_pc_inc;
                  r_pc      <= w_pc_inc;
                  r_state   <= ST_OP;
               end
            end
            ST_IMM: begin
               if (bus.redirect_en) begin
                  r_pc      <= bus.redirect_pc;
                  r_op_hold <= 8'h00;
                  r_instr   <= NOP_INSTR;
                  r_imm     <= 8'h00;
                  r_valid   <= 1'b0;
                  r_state   <= ST_OP;
               end else if (bus.stall) begin
                  r_state <= ST_IMM;
               end else begin
                  r_instr   <= r_op_hold;
                  r_imm     <= bus.imem_data;
                  r_valid   <= 1'b1;
                  r_pc_next <= w_pc_inc;
                  r_pc      <= w_pc_inc;
                  r_state   <= ST_OP;
               end
            end
            default: begin
               r_state   <= ST_BOOT;
               r_pc      <= 8'h00;
               r_op_hold <= 8'h00;
               r_instr   <= NOP_INSTR;
               r_imm     <= 8'h00;
               r_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: byte memory model, scenario tasks with inline
// checks, and a delivery scoreboard fed by the tasks.
module tb_instruction_fetch;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] imm;
      logic [7:0] pcn;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] mem [256];
   exp_t       sb [$];
   int         checks = 0;
   int         errors = 0;

   instruction_fetch_if bus ();

   instruction_fetch #(.TWO_BYTE_OPC(4'd12), .NOP_INSTR(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_data = mem[bus.imem_addr];

   // A new delivery is a valid output after an edge that was not stalled
   always @(posedge clk) begin
      logic st;
      exp_t e;
      st = bus.stall;
      #2;
      if (rst_n && bus.if_valid && !st) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got instr=%h imm=%h pcn=%h", bus.if_instr, bus.if_imm, bus.if_pc_next);
         end else begin
            e = sb.pop_front();
            if (bus.if_instr !== e.instr || bus.if_imm !== e.imm || bus.if_pc_next !== e.pcn) begin
               errors++;
               $display("FAIL sb_delivery got %h/%h/%h exp %h/%h/%h",
                        bus.if_instr, bus.if_imm, bus.if_pc_next, e.instr, e.imm, e.pcn);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] i, input logic [7:0] m, input logic [7:0] p);
      exp_t e;
      e.instr = i; e.imm = m; e.pcn = p;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h10;
      mem[8'h10] = 8'h29;
      bus.stall = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 8'h00 || bus.if_imm !== 8'h00 || bus.if_pc_next !== 8'h00) begin
         errors++; $display("FAIL reset_out got v=%b i=%h m=%h p=%h exp 0/00/00/00", bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc_next);
      end
      step(); step();
      checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.imem_addr); end
   endtask

   task automatic test_boot();
      rst_n = 1'b1;
      checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL boot_addr0 got %h exp 00", bus.imem_addr); end
      push(8'h29, 8'h00, 8'h11);
      step();
      checks++; if (bus.imem_addr !== 8'h10 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL boot_addr1 got addr=%h v=%b exp 10/0", bus.imem_addr, bus.if_valid);
      end
      step();
      checks++; if (bus.if_instr !== 8'h29 || bus.if_valid !== 1'b1 || bus.if_pc_next !== 8'h11) begin
         errors++; $display("FAIL boot_first got i=%h v=%b p=%h exp 29/1/11", bus.if_instr, bus.if_valid, bus.if_pc_next);
      end
   endtask

   task automatic test_two_byte();
      mem[8'h11] = 8'hC3; mem[8'h12] = 8'h5A;
      step();
      checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h12) begin
         errors++; $display("FAIL two_byte_bubble got v=%b addr=%h exp 0/12", bus.if_valid, bus.imem_addr);
      end
      push(8'hC3, 8'h5A, 8'h13);
      step();
      checks++; if (bus.if_valid !== 1'b1 || bus.imem_addr !== 8'h13) begin
         errors++; $display("FAIL two_byte_done got v=%b addr=%h exp 1/13", bus.if_valid, bus.imem_addr);
      end
   endtask

   task automatic test_back_to_back();
      mem[8'h13] = 8'h01; mem[8'h14] = 8'h02; mem[8'h15] = 8'h03;
      push(8'h01, 8'h00, 8'h14); push(8'h02, 8'h00, 8'h15); push(8'h03, 8'h00, 8'h16);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, bus.if_valid); end
      end
      checks++; if (bus.imem_addr !== 8'h16) begin errors++; $display("FAIL b2b_addr got %h exp 16", bus.imem_addr); end
   endtask

   task automatic test_stall();
      mem[8'h16] = 8'hC4; mem[8'h17] = 8'h99; mem[8'h18] = 8'h05;
      step();
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus.imem_addr !== 8'h17 || bus.if_valid !== 1'b0 || bus.if_instr !== 8'h00 || bus.if_pc_next !== 8'h16) begin
            errors++; $display("FAIL stall_imm[%0d] got addr=%h v=%b i=%h p=%h exp 17/0/00/16", k, bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc_next);
         end
      end
      bus.stall = 1'b0;
      push(8'hC4, 8'h99, 8'h18);
      step();
      push(8'h05, 8'h00, 8'h19);
      step();
      bus.stall = 1'b1;
      step(); step();
      checks++; if (bus.if_instr !== 8'h05 || bus.if_valid !== 1'b1 || bus.if_pc_next !== 8'h19 || bus.imem_addr !== 8'h19) begin
         errors++; $display("FAIL stall_op got i=%h v=%b p=%h addr=%h exp 05/1/19/19", bus.if_instr, bus.if_valid, bus.if_pc_next, bus.imem_addr);
      end
      bus.stall = 1'b0;
   endtask

   task automatic test_redirect();
      mem[8'h19] = 8'hC6; mem[8'h40] = 8'h25;
      step();
      bus.redirect_en = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 8'h40;
      step();
      checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h40) begin
         errors++; $display("FAIL redirect_bubble got v=%b addr=%h exp 0/40", bus.if_valid, bus.imem_addr);
      end
      bus.redirect_en = 1'b0; bus.stall = 1'b0;
      push(8'h25, 8'h00, 8'h41);
      step();
      checks++; if (bus.if_instr !== 8'h25 || bus.if_pc_next !== 8'h41) begin
         errors++; $display("FAIL redirect_target got i=%h p=%h exp 25/41", bus.if_instr, bus.if_pc_next);
      end
   endtask

   task automatic test_wrap();
      mem[8'hFF] = 8'hC1; mem[8'h00] = 8'h77;
      bus.redirect_en = 1'b1; bus.redirect_pc = 8'hFF;
      step();
      bus.redirect_en = 1'b0;
      step();
      checks++; if (bus.imem_addr !== 8'h00 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_split got addr=%h v=%b exp 00/0", bus.imem_addr, bus.if_valid);
      end
      push(8'hC1, 8'h77, 8'h01);
      step();
      checks++; if (bus.if_pc_next !== 8'h01 || bus.imem_addr !== 8'h01) begin
         errors++; $display("FAIL wrap_two got p=%h addr=%h exp 01/01", bus.if_pc_next, bus.imem_addr);
      end
      mem[8'hFF] = 8'h33;
      bus.redirect_en = 1'b1;
      step();
      bus.redirect_en = 1'b0;
      push(8'h33, 8'h00, 8'h00);
      step();
      checks++; if (bus.if_pc_next !== 8'h00 || bus.imem_addr !== 8'h00 || bus.if_valid !== 1'b1) begin
         errors++; $display("FAIL wrap_one got p=%h addr=%h v=%b exp 00/00/1", bus.if_pc_next, bus.imem_addr, bus.if_valid);
      end
      mem[8'h00] = 8'h10;
   endtask

   task automatic test_async_reset();
      bus.redirect_en = 1'b1; bus.redirect_pc = 8'h16;
      step();
      bus.redirect_en = 1'b0;
      step();
      checks++; if (bus.imem_addr !== 8'h17) begin errors++; $display("FAIL areset_pre got addr=%h exp 17", bus.imem_addr); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 8'h00 || bus.if_pc_next !== 8'h00 || bus.imem_addr !== 8'h00) begin
         errors++; $display("FAIL areset_out got v=%b i=%h p=%h addr=%h exp 0/00/00/00", bus.if_valid, bus.if_instr, bus.if_pc_next, bus.imem_addr);
      end
      step(); step();
      rst_n = 1'b1;
      push(8'h29, 8'h00, 8'h11);
      step();
      checks++; if (bus.imem_addr !== 8'h10 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL areset_boot got addr=%h v=%b exp 10/0", bus.imem_addr, bus.if_valid);
      end
      step();
      checks++; if (bus.if_instr !== 8'h29 || bus.if_pc_next !== 8'h11 || bus.if_valid !== 1'b1) begin
         errors++; $display("FAIL areset_first got i=%h p=%h v=%b exp 29/11/1", bus.if_instr, bus.if_pc_next, bus.if_valid);
      end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_two_byte();
      test_back_to_back();
      test_stall();
      test_redirect();
      test_wrap();
      test_async_reset();
      #5;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
